glcm_axi_reader: RTL and testbench

AXI4 read-burst fetch engine feeding the GLCM co-occurrence counter. On a start pulse it reads the 32x32 source image (1024 bytes, 256 words) from DRAM at the given base address as 16 incrementing bursts of 16 beats. It emits each word as four 5-bit pixels with a word index over a valid/ready stream. It owns the AXI read address and read data channels of the GLCM top.

---
 rtl/glcm_axi_reader.sv | 156 +++++++++++++++
 tb/tb_glcm_axi_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glcm_axi_reader.sv
// AXI4 read-burst fetch engine: reads a 32x32 5-bit image as 16 INCR bursts of 16 beats
// and streams each word as four packed pixels. Optional response checking: GLCM_RD_RESP_CHECK_EN.
module glcm_axi_reader #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BURSTS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   arid_m_inf,
  output logic [ADDR_WIDTH-1:0] araddr_m_inf,
  output logic [3:0]            arlen_m_inf,
  output logic [2:0]            arsize_m_inf,
  output logic [1:0]            arburst_m_inf,
  output logic                  arvalid_m_inf,
  input  logic                  arready_m_inf,
  input  logic [ID_WIDTH-1:0]   rid_m_inf,
  input  logic [DATA_WIDTH-1:0] rdata_m_inf,
  input  logic [1:0]            rresp_m_inf,
  input  logic                  rlast_m_inf,
  input  logic                  rvalid_m_inf,
  output logic                  rready_m_inf,
  output logic                  out_valid,
  output logic [19:0]           out_pix,
  output logic [7:0]            out_idx,
  input  logic                  out_ready
);

  localparam int BCW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BCW-1:0]        burst_cnt;
  logic [3:0]            beat_cnt;
  logic                  beat_hs;
  logic                  last_beat;
  logic                  last_burst;

  assign arid_m_inf    = '0;
  assign arlen_m_inf   = 4'd15;
  assign arsize_m_inf  = 3'b010;
  assign arburst_m_inf = 2'b01;

  // NOTE: rready is a pure function of registered state and out_ready, so it can drop in
  // the same cycle the output register stalls; a continuous assign cannot infer a latch.
  assign rready_m_inf = (state == DATA) && (!out_valid || out_ready);
  assign beat_hs      = rvalid_m_inf && rready_m_inf;
  assign last_beat    = (beat_cnt == 4'd15);
  assign last_burst   = (burst_cnt == BCW'(NUM_BURSTS - 1));

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
  // the reset branch is synchronous and covers every register, mid-burst included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      base_q        <= '0;
      burst_cnt     <= '0;
      beat_cnt      <= '0;
      arvalid_m_inf <= 1'b0;
      araddr_m_inf  <= '0;
      out_valid     <= 1'b0;
      out_pix       <= '0;
      out_idx       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef GLCM_RD_RESP_CHECK_EN
      err           <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      // One-entry output register: load on an accepted beat, otherwise drain on out_ready.
      if (beat_hs) begin
        out_valid <= 1'b1;
        out_pix   <= {rdata_m_inf[28:24], rdata_m_inf[20:16], rdata_m_inf[12:8], rdata_m_inf[4:0]};
        out_idx   <= 8'({burst_cnt, beat_cnt});
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

`ifdef GLCM_RD_RESP_CHECK_EN
      if (beat_hs && ((rresp_m_inf != 2'b00) || (rlast_m_inf != last_beat))) begin
        err <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (start) begin
            base_q        <= {base_addr[ADDR_WIDTH-1:6], 6'b0};
            araddr_m_inf  <= {base_addr[ADDR_WIDTH-1:6], 6'b0};
            burst_cnt     <= '0;
            beat_cnt      <= '0;
            arvalid_m_inf <= 1'b1;
            busy          <= 1'b1;
`ifdef GLCM_RD_RESP_CHECK_EN
            err           <= 1'b0;
`endif
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (arready_m_inf) begin
            arvalid_m_inf <= 1'b0;
            state         <= DATA;
          end
        end
        DATA: begin
          // Burst length is fixed at 16, so the beat counter, not rlast, ends a burst.
          if (beat_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (last_beat) begin
              burst_cnt <= burst_cnt + BCW'(1);
              if (last_burst) begin
                state <= FIN;
              end else begin
                araddr_m_inf  <= base_q + (ADDR_WIDTH'(burst_cnt + BCW'(1)) << 6);
                arvalid_m_inf <= 1'b1;
                state         <= ADDR;
              end
            end
          end
        end
        FIN: begin
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GLCM_RD_RESP_CHECK_EN
  logic unused_inputs;
  assign unused_inputs = ^{rid_m_inf, base_addr[5:0], rdata_m_inf[31:29], rdata_m_inf[23:21],
                           rdata_m_inf[15:13], rdata_m_inf[7:5]};
`else
  assign err = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{rid_m_inf, base_addr[5:0], rdata_m_inf[31:29], rdata_m_inf[23:21],
                           rdata_m_inf[15:13], rdata_m_inf[7:5], rresp_m_inf, rlast_m_inf};
`endif

endmodule

// File: tb/tb_glcm_axi_reader.sv
// Bench for glcm_axi_reader: AXI read slave model plus an output scoreboard
// filled with the expected 256 words whenever an image fetch is started.
module tb_glcm_axi_reader;

`ifdef GLCM_RD_RESP_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done, err;
  logic [3:0]  arid_m_inf;
  logic [31:0] araddr_m_inf;
  logic [3:0]  arlen_m_inf;
  logic [2:0]  arsize_m_inf;
  logic [1:0]  arburst_m_inf;
  logic        arvalid_m_inf;
  logic        arready_m_inf = 1'b0;
  logic [3:0]  rid_m_inf = '0;
  logic [31:0] rdata_m_inf = '0;
  logic [1:0]  rresp_m_inf = '0;
  logic        rlast_m_inf = 1'b0;
  logic        rvalid_m_inf = 1'b0;
  logic        rready_m_inf;
  logic        out_valid;
  logic [19:0] out_pix;
  logic [7:0]  out_idx;
  logic        out_ready = 1'b0;

  glcm_axi_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .arid_m_inf(arid_m_inf), .araddr_m_inf(araddr_m_inf), .arlen_m_inf(arlen_m_inf),
    .arsize_m_inf(arsize_m_inf), .arburst_m_inf(arburst_m_inf),
    .arvalid_m_inf(arvalid_m_inf), .arready_m_inf(arready_m_inf),
    .rid_m_inf(rid_m_inf), .rdata_m_inf(rdata_m_inf), .rresp_m_inf(rresp_m_inf),
    .rlast_m_inf(rlast_m_inf), .rvalid_m_inf(rvalid_m_inf), .rready_m_inf(rready_m_inf),
    .out_valid(out_valid), .out_pix(out_pix), .out_idx(out_idx), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [19:0] pix;
    logic [7:0]  idx;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hFFE3_A1C7;
    return (a * 32'h9E37_79B1) ^ 32'h3C5A_96E1 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [19:0] pix_of(input logic [31:0] w);
    return {w[28:24], w[20:16], w[12:8], w[4:0]};
  endfunction

  // Slave / monitor knobs and state.
  bit          fast_ar = 1'b1;
  int          ar_delay = 0;
  bit          rv_rand = 1'b0;
  bit          or_rand = 1'b0;
  int          err_beat = -1;
  bit          s_busy = 1'b0;
  bit          r_taken = 1'b0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] s_addr = '0;
  logic [31:0] exp_base = '0;
  int          s_beat = 0;
  int          s_gbeat = 0;
  int          ar_wait = 0;
  int          ar_cnt = 0;
  int          pops = 0;
  int          last_pop_cyc = 0;
  logic [19:0] first_pix = '0;

  // Drive on the falling edge, evaluate handshakes just before the rising edge.
  always begin : slave
    bit   ar_hs, r_hs, o_hs;
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      s_busy = 1'b0; r_taken = 1'b0; prev_pend = 1'b0; ar_wait = 0;
      rvalid_m_inf = 1'b0; arready_m_inf = 1'b0;
    end else begin
      if (fast_ar) arready_m_inf = 1'b1;
      else if (arvalid_m_inf) begin
        arready_m_inf = (ar_wait >= ar_delay);
        ar_wait++;
      end else begin
        arready_m_inf = 1'b0;
        ar_wait = 0;
      end
      if (!rvalid_m_inf || r_taken) begin
        r_taken = 1'b0;
        if (s_busy && (!rv_rand || $urandom_range(0, 1) == 1)) begin
          rvalid_m_inf = 1'b1;
          rdata_m_inf  = mem_word(s_addr + 32'(s_beat) * 4);
          rlast_m_inf  = (s_beat == 15);
          rresp_m_inf  = (s_gbeat == err_beat) ? 2'b10 : 2'b00;
        end else begin
          rvalid_m_inf = 1'b0;
        end
      end
      out_ready = or_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #4;
    if (rst_n) begin
      ar_hs = arvalid_m_inf && arready_m_inf;
      r_hs  = rvalid_m_inf && rready_m_inf;
      o_hs  = out_valid && out_ready;
      if (prev_pend) begin
        check("ar_hold_valid", 32'(arvalid_m_inf), 32'd1);
        check("ar_hold_addr", araddr_m_inf, prev_addr);
      end
      if (s_busy) check("ar_outstanding", 32'(arvalid_m_inf), 32'd0);
      if (arvalid_m_inf) check("rready_before_ar", 32'(rready_m_inf), 32'd0);
      if (out_valid && !out_ready) check("rready_backpressure", 32'(rready_m_inf), 32'd0);
      if (r_hs) begin
        r_taken = 1'b1;
        s_beat++;
        s_gbeat++;
        if (s_beat == 16) s_busy = 1'b0;
      end
      if (ar_hs) begin
        check("araddr", araddr_m_inf, exp_base + 32'(ar_cnt) * 64);
        ar_cnt++;
        ar_wait = 0;
        s_busy = 1'b1;
        s_addr = araddr_m_inf;
        s_beat = 0;
      end
      if (o_hs) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_idx), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_pix", 32'(out_pix), 32'(e.pix));
          check("out_idx", 32'(out_idx), 32'(e.idx));
        end
        if (pops == 0) first_pix = out_pix;
        pops++;
        last_pop_cyc = cyc;
      end
      prev_pend = arvalid_m_inf && !arready_m_inf;
      prev_addr = araddr_m_inf;
    end
  end

  int t_start = 0;
  int done_cyc = 0;

  task automatic check_idle_outputs();
    check("rst_arvalid", 32'(arvalid_m_inf), 32'd0);
    check("rst_rready", 32'(rready_m_inf), 32'd0);
    check("rst_araddr", araddr_m_inf, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("arid", 32'(arid_m_inf), 32'd0);
    check("arlen", 32'(arlen_m_inf), 32'd15);
    check("arsize", 32'(arsize_m_inf), 32'd2);
    check("arburst", 32'(arburst_m_inf), 32'd1);
  endtask

  task automatic begin_image(input logic [31:0] b);
    logic [31:0] aligned;
    aligned = {b[31:6], 6'b0};
    sb.delete();
    for (int i = 0; i < 256; i++) sb.push_back('{pix: pix_of(mem_word(aligned + 32'(i) * 4)), idx: 8'(i)});
    exp_base = aligned;
    ar_cnt = 0; pops = 0; s_gbeat = 0;
    s_busy = 1'b0; r_taken = 1'b0; prev_pend = 1'b0;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    t_start = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("arvalid_rise", 32'(arvalid_m_inf), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic finish_image(input int budget, input bit exp_err);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      done_cyc = cyc;
      check("done_latency", 32'(cyc - last_pop_cyc), 32'd1);
      check("busy_fall", 32'(busy), 32'd0);
      check("words_left", 32'(sb.size()), 32'd0);
      check("ar_count", 32'(ar_cnt), 32'd16);
      check("err_at_done", 32'(err), 32'(exp_err));
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k;
    k = 0;
    while (pops < n && k < budget) begin @(negedge clk); k++; end
    check("wait_pops", 32'(pops >= n), 32'd1);
  endtask

  task automatic wait_gbeat(input int n, input int budget);
    int k;
    k = 0;
    while (s_gbeat < n && k < budget) begin @(negedge clk); k++; end
    check("wait_beats", 32'(s_gbeat >= n), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back throughput with an always-ready slave and sink.
    begin_image(32'h0000_1000);
    finish_image(400, 1'b0);
    check("cycle_budget", 32'((done_cyc - t_start) <= 16 * (16 + 3) + 4), 32'd1);
    check("pix_word0", 32'(first_pix), 32'({5'h1F, 5'h03, 5'h01, 5'h07}));

    // Random rvalid gaps, random sink stalls, AR delayed 5 cycles, unaligned base.
    fast_ar = 1'b0; ar_delay = 5; rv_rand = 1'b1; or_rand = 1'b1;
    begin_image(32'h0000_302A);
    finish_image(6000, 1'b0);
    fast_ar = 1'b1; ar_delay = 0; rv_rand = 1'b0; or_rand = 1'b0;

    // SLVERR on beat 37.
    err_beat = 37;
    begin_image(32'h0000_4000);
    wait_gbeat(37, 200);
    check("err_before_bad_beat", 32'(err), 32'd0);
    wait_gbeat(39, 200);
    check("err_after_bad_beat", 32'(err), 32'(ERR_EN));
    finish_image(400, ERR_EN);
    err_beat = -1;

    // Second start mid-transfer is ignored; reset at word 100 abandons the burst.
    begin_image(32'h0000_1000);
    wait_pops(50, 200);
    start = 1'b1;
    base_addr = 32'h0000_7000;
    @(negedge clk);
    start = 1'b0;
    check("busy_hold", 32'(busy), 32'd1);
    wait_pops(101, 200);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_image(32'h0000_2000);
    finish_image(400, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
